// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width derivation and Gray/binary
// conversion, used by both the read- and write-side pointer controllers.
package fifo_pkg;

  // Pointers carry one extra MSB beyond the address so full and empty
  // can be told apart when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  // Binary to Gray on the low w bits; bits at or above w are returned as 0.
  function automatic logic [31:0] bin2gray(input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] t;
    logic [31:0] g;
    t = b ^ (b >> 1);
    g = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(w)) g[i] = t[i];
    end
    return g;
  endfunction

  // Gray to binary on the low w bits: each binary bit is the XOR of all
  // Gray bits at and above it within the width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g,
                                           input int unsigned w);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of parametrised width.
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] grayIn,
  output logic [W-1:0] binOut
);

  // Pure prefix-XOR from the MSB down; no state.
  always_comb begin
    binOut = W'(gray2bin(32'(grayIn), W));
  end

endmodule

// File: rtl/read_ptr_ctrl.sv
// Read-side pointer controller for the async FIFO (read clock domain).
// Holds binary/Gray read pointers, empty and almost-empty flags, occupancy,
// a sticky underflow flag and a read-valid strobe aligned to a one-cycle
// registered memory read.
module read_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned addrWidth = 4
) (
  input  logic                 readClkIn,
  input  logic                 readRstIn,
  input  logic                 readEnableIn,
  input  logic [addrWidth:0]   syncedWritePtrIn,
  input  logic [addrWidth:0]   almostEmptyThreshIn,
  input  logic                 underflowClearIn,
  output logic [addrWidth-1:0] readAddrOut,
  output logic [addrWidth:0]   readPtrOut,
  output logic                 fifoEmptyOut,
  output logic                 almostEmptyOut,
  output logic [addrWidth:0]   fillLevelOut,
  output logic                 underflowOut,
  output logic                 readValidOut
);

  localparam int unsigned PTR_W = ptr_width(addrWidth);

  logic [PTR_W-1:0] read_bin_q,  read_bin_d;
  logic [PTR_W-1:0] read_gray_q, read_gray_d;
  logic [PTR_W-1:0] fill_q,      fill_d;
  logic             empty_q,     empty_d;
  logic             aempty_q,    aempty_d;
  logic             uflow_q,     uflow_d;
  logic             rvalid_q,    rvalid_d;

  logic             accept;
  logic             uflow_set;
  logic [PTR_W-1:0] write_bin_sync;

  gray_to_bin #(.W(PTR_W)) u_wptr_g2b (
    .grayIn (syncedWritePtrIn),
    .binOut (write_bin_sync)
  );

  // Next-state: flags and occupancy are taken against the post-pop pointer
  // so a pop of the last word shows empty on the very next edge.
  always_comb begin
    accept      = readEnableIn & ~empty_q;
    uflow_set   = readEnableIn & empty_q;
    read_bin_d  = read_bin_q + PTR_W'(accept);
    read_gray_d = PTR_W'(bin2gray(32'(read_bin_d), PTR_W));
    fill_d      = write_bin_sync - read_bin_d;
    empty_d     = (read_gray_d == syncedWritePtrIn);
    aempty_d    = (fill_d <= almostEmptyThreshIn);
    // Set dominates a same-cycle clear so no underflow is ever lost.
    uflow_d     = uflow_set | (uflow_q & ~underflowClearIn);
    rvalid_d    = accept;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge readClkIn) begin
    if (readRstIn) begin
      read_bin_q  <= '0;
      read_gray_q <= '0;
      fill_q      <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      uflow_q     <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      read_bin_q  <= read_bin_d;
      read_gray_q <= read_gray_d;
      fill_q      <= fill_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      uflow_q     <= uflow_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign readAddrOut    = read_bin_q[addrWidth-1:0];
  assign readPtrOut     = read_gray_q;
  assign fifoEmptyOut   = empty_q;
  assign almostEmptyOut = aempty_q;
  assign fillLevelOut   = fill_q;
  assign underflowOut   = uflow_q;
  assign readValidOut   = rvalid_q;

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Bench for read_ptr_ctrl (addrWidth = 4). The reference model tracks read
// and write counts as plain integers and derives every output from them.
module tb_read_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [4:0] wptr;
  logic [4:0] thr;
  logic [3:0] addr_o;
  logic [4:0] ptr_o;
  logic       empty_o;
  logic       ae_o;
  logic [4:0] fill_o;
  logic       uf_o;
  logic       rv_o;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_rd, m_wr, m_fill;
  bit m_empty, m_ae, m_uf, m_rv;

  always #5 clk = ~clk;

  read_ptr_ctrl #(.addrWidth(4)) dut (
    .readClkIn           (clk),
    .readRstIn           (rst),
    .readEnableIn        (en),
    .syncedWritePtrIn    (wptr),
    .almostEmptyThreshIn (thr),
    .underflowClearIn    (clr),
    .readAddrOut         (addr_o),
    .readPtrOut          (ptr_o),
    .fifoEmptyOut        (empty_o),
    .almostEmptyOut      (ae_o),
    .fillLevelOut        (fill_o),
    .underflowOut        (uf_o),
    .readValidOut        (rv_o)
  );

  function automatic logic [4:0] gray5(input int x);
    int v;
    v = x & 31;
    return 5'(v ^ (v >> 1));
  endfunction

  function automatic logic [17:0] dut_vec();
    return {addr_o, ptr_o, empty_o, ae_o, fill_o, uf_o, rv_o};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {4'(m_rd & 15), gray5(m_rd), m_empty, m_ae, 5'(m_fill), m_uf, m_rv};
  endfunction

  task automatic set_wr(input int w);
    m_wr = w & 31;
    wptr = gray5(m_wr);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // settle 1 time unit past the edge for sampling.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (rst) begin
      m_rd = 0; m_fill = 0; m_empty = 1; m_ae = 1; m_uf = 0; m_rv = 0;
    end else begin
      acc     = en && !m_empty;
      m_uf    = (en && m_empty) || (m_uf && !clr);
      m_rd    = (m_rd + int'(acc)) & 31;
      m_fill  = (m_wr - m_rd) & 31;
      m_empty = (m_fill == 0);
      m_ae    = (m_fill <= int'(thr));
      m_rv    = acc;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; clr = 0;
    set_wr(0);
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; clr = 0; thr = 5'd2;
    set_wr(0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({empty_o, ae_o, ptr_o, fill_o, uf_o, rv_o} !== {1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset[%0d] got e=%b ae=%b ptr=%h fill=%0d uf=%b rv=%b want e=1 ae=1 ptr=0 fill=0 uf=0 rv=0",
                 i, empty_o, ae_o, ptr_o, fill_o, uf_o, rv_o);
      end
    end
    rst = 0; en = 0;
  endtask

  task automatic test_fill_drain();
    do_reset();
    thr = 5'd2;
    set_wr(5);
    n_cmp++;
    if (wptr !== 5'b00111) begin
      n_bad++;
      $display("FAIL gray5_stim got %b want 00111", wptr);
    end
    tick();
    n_cmp++;
    if ({fill_o, empty_o, ae_o} !== {5'd5, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fill5 got fill=%0d e=%b ae=%b want fill=5 e=0 ae=0", fill_o, empty_o, ae_o);
    end
    en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({fill_o, ae_o, empty_o, rv_o, addr_o} !==
          {5'(4 - i), 1'((4 - i) <= 2), 1'(i == 4), 1'b1, 4'(i + 1)}) begin
        n_bad++;
        $display("FAIL drain[%0d] got fill=%0d ae=%b e=%b rv=%b addr=%0d want fill=%0d ae=%b e=%b rv=1 addr=%0d",
                 i, fill_o, ae_o, empty_o, rv_o, addr_o, 4 - i, (4 - i) <= 2, i == 4, i + 1);
      end
    end
    en = 0;
    tick();
    n_cmp++;
    if ({rv_o, empty_o, uf_o} !== {1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL drain_idle got rv=%b e=%b uf=%b want rv=0 e=1 uf=0", rv_o, empty_o, uf_o);
    end
  endtask

  task automatic test_underflow();
    // continues from drained state: read pointer at 5
    en = 1; clr = 0;
    tick();
    n_cmp++;
    if ({uf_o, ptr_o, rv_o} !== {1'b1, 5'b00111, 1'b0}) begin
      n_bad++;
      $display("FAIL uf_set got uf=%b ptr=%b rv=%b want uf=1 ptr=00111 rv=0", uf_o, ptr_o, rv_o);
    end
    en = 0;
    tick();
    n_cmp++;
    if (uf_o !== 1'b1) begin
      n_bad++;
      $display("FAIL uf_sticky got %b want 1", uf_o);
    end
    en = 1; clr = 1;
    tick();
    n_cmp++;
    if (uf_o !== 1'b1) begin
      n_bad++;
      $display("FAIL uf_set_beats_clr got %b want 1", uf_o);
    end
    en = 0; clr = 1;
    tick();
    n_cmp++;
    if (uf_o !== 1'b0) begin
      n_bad++;
      $display("FAIL uf_clear got %b want 0", uf_o);
    end
    clr = 0;
  endtask

  task automatic test_wrap();
    int pops;
    do_reset();
    thr = 5'd1;
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      set_wr(m_wr + 1);
      en = 0;
      tick();
      en = 1;
      tick();
      pops++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL wrap_pop%0d got %h want %h", pops, dut_vec(), exp_vec());
      end
      if (pops == 16 || pops == 32) begin
        n_cmp++;
        if ({addr_o, ptr_o[4], fill_o} !== {4'd0, 1'(pops == 16), 5'd0}) begin
          n_bad++;
          $display("FAIL wrap_edge%0d got addr=%0d msb=%b fill=%0d want addr=0 msb=%b fill=0",
                   pops, addr_o, ptr_o[4], fill_o, pops == 16);
        end
      end
    end
    en = 0;
  endtask

  task automatic test_full();
    do_reset();
    thr = 5'd16;
    set_wr(16);
    tick();
    n_cmp++;
    if ({fill_o, empty_o, ae_o} !== {5'd16, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL full_t16 got fill=%0d e=%b ae=%b want fill=16 e=0 ae=1", fill_o, empty_o, ae_o);
    end
    thr = 5'd15;
    tick();
    n_cmp++;
    if ({fill_o, ae_o} !== {5'd16, 1'b0}) begin
      n_bad++;
      $display("FAIL full_t15 got fill=%0d ae=%b want fill=16 ae=0", fill_o, ae_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 3) != 0) && (((m_wr - m_rd) & 31) < 16))
        set_wr(m_wr + 1);
      en  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      if ((i % 50) == 0) thr = 5'($urandom_range(0, 17));
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random[%0d] got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    en = 0; clr = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    thr = 5'd3;
    set_wr(7);
    tick();
    en = 1;
    tick();
    tick();
    n_cmp++;
    if (fill_o !== 5'd5) begin
      n_bad++;
      $display("FAIL mid_fill got %0d want 5", fill_o);
    end
    rst = 1;
    set_wr(0);
    tick();
    n_cmp++;
    if ({addr_o, ptr_o, empty_o, ae_o, fill_o, uf_o, rv_o} !== {4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset got %h want %h", dut_vec(), {4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0});
    end
    rst = 0;
    tick();
    n_cmp++;
    if ({uf_o, ptr_o, rv_o} !== {1'b1, 5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_pop_rejected got uf=%b ptr=%h rv=%b want uf=1 ptr=0 rv=0", uf_o, ptr_o, rv_o);
    end
    en = 0;
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; thr = 5'd0; wptr = 5'd0;
    m_rd = 0; m_wr = 0; m_fill = 0;
    m_empty = 1; m_ae = 1; m_uf = 0; m_rv = 0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_full();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
